// File: rtl/pong_pkg.sv
// Shared types and geometry helpers for the pong paddle datapath.
// Position limits derive from paddle length and matrix height.
package pong_pkg;

    localparam int SIZE_DEF  = 2;
    localparam int WIDTH_DEF = 8;

    typedef logic [2:0] pos_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    function automatic pos_t pos_min();
        return pos_t'(1);
    endfunction

    function automatic pos_t pos_max(int size, int width);
        return pos_t'(width - 1 - size);
    endfunction

    function automatic pos_t pos_reset(int size, int width);
        return pos_t'((width - size) / 2);
    endfunction

    localparam pos_t POS_MIN   = pos_min();
    localparam pos_t POS_MAX   = pos_max(SIZE_DEF, WIDTH_DEF);
    localparam pos_t POS_RESET = pos_reset(SIZE_DEF, WIDTH_DEF);

endpackage

// File: rtl/paddle_control_if.sv
// Button inputs and paddle position outputs of one player.
// The game side drives buttons; the paddle block drives position.
interface paddle_control_if;
    import pong_pkg::*;

    logic btn_up;
    logic btn_down;
    pos_t player_down;
    logic moved;

    modport master (
        output btn_up,
        output btn_down,
        input  player_down,
        input  moved
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        output player_down,
        output moved
    );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a stable-level debouncer.
// db only follows s after DEBOUNCE_CYCLES consecutive differing samples.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic db
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        meta;
    logic        s;
    logic [15:0] cnt;

    // synchronise the raw level, then count how long it disagrees with db
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            s    <= 1'b0;
            db   <= 1'b0;
            cnt  <= '0;
        end else begin
            meta <= btn;
            s    <= meta;
            if (s == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/paddle_control.sv
// Debounced up/down buttons step the paddle with hold-to-repeat.
// Position saturates at the rows next to the matrix border.
module paddle_control
    import pong_pkg::*;
#(
    parameter int SIZE            = SIZE_DEF,
    parameter int WIDTH           = WIDTH_DEF,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_DELAY      = 12500000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    paddle_control_if.slave  io
);

    localparam pos_t        PMIN      = pos_min();
    localparam pos_t        PMAX      = pos_max(SIZE, WIDTH);
    localparam pos_t        PRST      = pos_reset(SIZE, WIDTH);
    localparam logic [23:0] HOLD_LAST = 24'(HOLD_DELAY - 1);
    localparam logic [23:0] REP_LAST  = 24'(REPEAT_PERIOD - 1);

    logic        up_db;
    logic        dn_db;
    state_t      state;
    state_t      state_nxt;
    dir_t        dir;
    dir_t        step_dir;
    logic [23:0] timer;
    pos_t        pos;
    logic        moved_q;
    logic        step;
    logic        tmr_clr;
    logic        tmr_inc;
    logic        one_up;
    logic        one_dn;
    logic        held;
    logic        hit;
    logic        can_move;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_up (
        .clk   (clk),
        .reset (reset),
        .btn   (io.btn_up),
        .db    (up_db)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_dn (
        .clk   (clk),
        .reset (reset),
        .btn   (io.btn_down),
        .db    (dn_db)
    );

    assign one_up = up_db & ~dn_db;
    assign one_dn = dn_db & ~up_db;
    assign held   = (dir == UP) ? one_up : one_dn;
    assign hit    = (state == DELAY) ? (timer == HOLD_LAST)
                                     : (timer == REP_LAST);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state: leave the hold as soon as the latched button is not alone
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (one_up || one_dn) state_nxt = DELAY;
            end
            DELAY: begin
                if (!held)    state_nxt = IDLE;
                else if (hit) state_nxt = REPEAT;
            end
            REPEAT: begin
                if (!held) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: step request, its direction and timer control
    always_comb begin
        step     = 1'b0;
        step_dir = dir;
        tmr_clr  = 1'b0;
        tmr_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (one_up || one_dn) begin
                    step     = 1'b1;
                    step_dir = one_dn ? DOWN : UP;
                    tmr_clr  = 1'b1;
                end
            end
            DELAY, REPEAT: begin
                if (held) begin
                    if (hit) begin
                        step    = 1'b1;
                        tmr_clr = 1'b1;
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // a step at a border row is swallowed without a moved pulse
    assign can_move = step && ((step_dir == UP) ? (pos > PMIN)
                                                : (pos < PMAX));

    // direction latch, hold timer and registered paddle position
    always_ff @(posedge clk) begin
        if (reset) begin
            dir     <= UP;
            timer   <= '0;
            pos     <= PRST;
            moved_q <= 1'b0;
        end else begin
            dir     <= step_dir;
            moved_q <= can_move;
            if (tmr_clr)      timer <= '0;
            else if (tmr_inc) timer <= timer + 24'd1;
            if (can_move) begin
                pos <= (step_dir == UP) ? pos - 3'd1 : pos + 3'd1;
            end
        end
    end

    assign io.player_down = pos;
    assign io.moved       = moved_q;

endmodule

// File: tb/tb_paddle_control.sv
// Directed bench for paddle_control with a step scoreboard.
// Expected (cycle, position) steps are queued as buttons are driven.
module tb_paddle_control;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int REP  = 4;
    localparam int LAT  = DEB + 3;

    typedef struct {
        int cyc;
        int pos;
    } exp_t;

    logic clk;
    logic reset;
    int   n_asserts;
    int   n_fail;
    int   cyc;
    logic prev_moved;
    exp_t q[$];

    paddle_control_if pif ();

    paddle_control #(
        .SIZE            (2),
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_DELAY      (HOLD),
        .REPEAT_PERIOD   (REP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one clock, then score any moved pulse against the queue
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (pif.moved === 1'b1) begin
            check("moved_gap", 32'(prev_moved), 0);
            check("step_expected", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("step_cycle", cyc, e.cyc);
                check("step_pos", 32'(pif.player_down), e.pos);
            end
        end else if (q.size() > 0 && cyc >= q[0].cyc) begin
            e = q.pop_front();
            check("step_missed", 32'(pif.moved), 1);
        end
        prev_moved = pif.moved;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int c;
        int r;
        n_asserts    = 0;
        n_fail       = 0;
        cyc          = 0;
        prev_moved   = 1'b0;
        reset        = 1'b1;
        pif.btn_up   = 1'($urandom_range(0, 1));
        pif.btn_down = 1'($urandom_range(0, 1));

        // reset with random buttons
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_pos", 32'(pif.player_down), 3);
            check("rst_moved", 32'(pif.moved), 0);
            pif.btn_up   = 1'($urandom_range(0, 1));
            pif.btn_down = 1'($urandom_range(0, 1));
        end
        reset        = 1'b0;
        pif.btn_up   = 1'b0;
        pif.btn_down = 1'b0;
        tick();
        check("rel_pos", 32'(pif.player_down), 3);
        check("rel_moved", 32'(pif.moved), 0);
        ticks(4);

        // glitches of 1..3 cycles
        for (int w = 1; w <= 3; w++) begin
            pif.btn_up = 1'b1;
            ticks(w);
            pif.btn_up = 1'b0;
            ticks(10);
            check("glitch_pos", 32'(pif.player_down), 3);
        end

        // single press down
        c = cyc;
        pif.btn_down = 1'b1;
        q.push_back('{c + LAT, 4});
        ticks(8);
        pif.btn_down = 1'b0;
        ticks(12);
        check("press_dn_pos", 32'(pif.player_down), 4);
        check("press_dn_q", q.size(), 0);

        // single press up
        c = cyc;
        pif.btn_up = 1'b1;
        q.push_back('{c + LAT, 3});
        ticks(8);
        pif.btn_up = 1'b0;
        ticks(12);
        check("press_up_pos", 32'(pif.player_down), 3);
        check("press_up_q", q.size(), 0);

        // auto-repeat up into the top limit
        c = cyc;
        pif.btn_up = 1'b1;
        q.push_back('{c + LAT, 2});
        q.push_back('{c + LAT + HOLD, 1});
        ticks(LAT + HOLD + REP);
        check("rpt_sat0", 32'(pif.player_down), 1);
        ticks(REP);
        check("rpt_sat1", 32'(pif.player_down), 1);
        ticks(REP);
        check("rpt_sat2", 32'(pif.player_down), 1);
        pif.btn_up = 1'b0;
        ticks(12);
        check("rpt_pos", 32'(pif.player_down), 1);
        check("rpt_q", q.size(), 0);

        // both buttons: up joins while down is in its hold delay
        c = cyc;
        pif.btn_down = 1'b1;
        q.push_back('{c + LAT, 2});
        ticks(8);
        pif.btn_up = 1'b1;
        ticks(20);
        check("both_pos", 32'(pif.player_down), 2);
        check("both_q", q.size(), 0);
        r = cyc;
        pif.btn_up = 1'b0;
        q.push_back('{r + LAT, 3});
        ticks(8);
        pif.btn_down = 1'b0;
        ticks(12);
        check("both_rel_pos", 32'(pif.player_down), 3);
        check("both_rel_q", q.size(), 0);

        // reset while repeating at the bottom limit
        c = cyc;
        pif.btn_down = 1'b1;
        q.push_back('{c + LAT, 4});
        q.push_back('{c + LAT + HOLD, 5});
        ticks(LAT + HOLD + REP + 2);
        check("hold_pos", 32'(pif.player_down), 5);
        reset = 1'b1;
        tick();
        check("midrst_pos", 32'(pif.player_down), 3);
        check("midrst_moved", 32'(pif.moved), 0);
        reset = 1'b0;
        r = cyc;
        q.push_back('{r + LAT, 4});
        ticks(8);
        pif.btn_down = 1'b0;
        ticks(12);
        check("postrst_pos", 32'(pif.player_down), 4);
        check("postrst_q", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule
